ps2_scancode_rx: RTL
====================

Name: ps2_scancode_rx

Overview:
- PS/2 keyboard receive front end that sits directly downstream of the PS2_CLK/PS2_DATA board pins and upstream of the BBC keyboard matrix emulation.
- Synchronises and filters the PS/2 lines, then deframes 11-bit device-to-host frames.
- Folds E0 (extended) and F0 (break) prefixes into flags on the following code.
- Buffers decoded key events in a small FIFO, read through a valid/ready handshake.

Parameters:
- FILTER, 8, consecutive system-clock cycles a synchronised PS2_CLK level must hold before the filtered clock changes.
- TIMEOUT, 20000, system-clock cycles without a filtered falling edge, while mid-frame, before the frame is aborted.
- FIFO_DEPTH, 4, event FIFO entries; power of two, 2 or greater.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- nRESET  input  1  synchronous active-low reset.
- PS2_CLK  input  1  raw PS/2 clock from the pin; asynchronous.
- PS2_DATA  input  1  raw PS/2 data from the pin; asynchronous.
- OUT_READY  input  1  consumer accepts the head entry this cycle.
- OUT_VALID  output  1  FIFO non-empty.
- OUT_CODE  output  8  head-entry scan code.
- OUT_BREAK  output  1  head entry was preceded by F0 (key release).
- OUT_EXT  output  1  head entry was preceded by E0.
- FRAME_ERR  output  1  one-cycle pulse when a frame is discarded.
- OVERFLOW  output  1  one-cycle pulse when an event is dropped because the FIFO is full.

Behaviour:
- Reset (nRESET=0 at a CLK edge):
  - All outputs 0; FIFO empty.
  - Bit counter 0; prefix flags cleared.
  - Synchronisers and filtered clock preset to 1 (idle).
- Synchronisation and filter:
  - Each pin passes through a 2-flop synchroniser.
  - The filtered clock toggles only after the synchronised clock has differed from it for FILTER consecutive cycles.
  - A fall-edge strobe fires on the cycle the filtered clock goes 1->0; the synchronised data bit is sampled on that same cycle.
- Deframing (bit counter 0..10):
  - Bit 0 is the start bit and must be 0. If it is 1, it is ignored silently and the counter stays at 0 (line noise, not an error).
  - Bits 1-8 are data, LSB first, shifted in.
  - Bit 9 is parity, odd: XOR of the 8 data bits and the parity bit must equal 1.
  - Bit 10 is the stop bit and must be 1.
  - On bit 10 the counter returns to 0. If parity and stop are good, the byte is decoded on the next cycle. Otherwise FRAME_ERR pulses on the next cycle, the byte is discarded and the prefix flags are cleared.
- Timeout:
  - While the counter is non-zero, a watchdog counts cycles since the last fall-edge strobe.
  - When it reaches TIMEOUT: counter set to 0, FRAME_ERR pulses, prefix flags cleared.
  - The watchdog is held at 0 while the counter is 0.
- Decode of a good byte:
  - E0: set ext flag; nothing pushed.
  - F0: set break flag; nothing pushed.
  - Any other value, including E1: push {code, break flag, ext flag}, then clear both flags.
  - Repeated prefixes (E0 E0, F0 F0) leave the flag at 1.
- FIFO:
  - Push occurs the cycle after the stop bit is sampled. OUT_VALID rises the cycle after the push (registered outputs).
  - Pop when OUT_VALID and OUT_READY are both 1 at a clock edge. OUT_CODE, OUT_BREAK and OUT_EXT hold stable while OUT_VALID=1 and OUT_READY=0.
  - Push while full and no pop: the new event is dropped, OVERFLOW pulses, and FIFO contents are unchanged.
  - Push and pop in the same cycle when full: both occur, no OVERFLOW, and the count is unchanged.
  - Push and pop in the same cycle when empty: not possible, because OUT_VALID is 0.
  - Pointers wrap modulo FIFO_DEPTH. The count is kept at log2(FIFO_DEPTH)+1 bits.
- Reset mid-frame or with the FIFO holding data: every state returns to reset values immediately, and OUT_VALID is 0 on the following cycle.
- Glitches on PS2_CLK shorter than FILTER cycles produce no fall-edge strobe.

Test Plan:
- Frame 0x1C (data bits 0,0,1,1,1,0,0,0 LSB first; parity 0; stop 1) at a PS/2 period of 2048 cycles, data changed 500 cycles after each rising edge, OUT_READY=1 -> one OUT_VALID beat with OUT_CODE=0x1C, OUT_BREAK=0, OUT_EXT=0; FRAME_ERR stays 0.
- Frames F0 then 1C -> single beat with OUT_CODE=0x1C, OUT_BREAK=1. Then frames E0, F0, 75 -> single beat with OUT_CODE=0x75, OUT_BREAK=1, OUT_EXT=1. No beats for the prefixes.
- Frame 0x1C sent with parity bit 1 -> FRAME_ERR pulses once and no push. A following good frame 0x1B is delivered with OUT_BREAK=0 even if F0 preceded the bad frame.
- Send 5 good codes 0x16, 0x1E, 0x26, 0x25, 0x2E with OUT_READY=0 and FIFO_DEPTH=4 -> OVERFLOW pulses once, on the 5th code. Then raise OUT_READY -> beats 0x16, 0x1E, 0x26, 0x25 in order, then OUT_VALID=0.
- Stop PS2_CLK after 4 bits -> FRAME_ERR exactly TIMEOUT cycles after the last fall-edge strobe. A following complete frame 0x5A is received correctly.
- Apply 3-cycle low glitches on PS2_CLK while idle, and assert nRESET=0 mid-frame with the FIFO non-empty -> no strobes or pushes from the glitches; after the reset, OUT_VALID=0 and the next full frame 0x45 is decoded correctly.

Source files
------------

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receive front end: synchronises and filters the pins,
// deframes 11-bit device-to-host frames, folds E0/F0 prefixes into flags
// and buffers key events in a small FIFO behind a valid/ready handshake.
module ps2_scancode_rx #(
  parameter int FILTER     = 8,
  parameter int TIMEOUT    = 20000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  input  logic       OUT_READY,
  output logic       OUT_VALID,
  output logic [7:0] OUT_CODE,
  output logic       OUT_BREAK,
  output logic       OUT_EXT,
  output logic       FRAME_ERR,
  output logic       OVERFLOW
);

  localparam int FILT_W = $clog2(FILTER + 1);
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } event_t;

  // Synchroniser / filter state
  logic              clk_meta, clk_sync, data_meta, data_sync;
  logic              filt_clk;
  logic [FILT_W-1:0] filt_cnt;
  logic              fall_edge;

  // Deframer state
  logic [3:0]        bit_cnt;
  logic [7:0]        shift_q;
  logic              par_q;
  logic [WD_W-1:0]   wd;
  logic              frame_done, frame_ok;
  logic              timeout_hit;

  // Prefix decode
  logic              brk_q, ext_q;
  logic              push;
  event_t            push_ev;

  // FIFO
  event_t            mem [FIFO_DEPTH];
  event_t            head;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full, pop, wr_en;

  // The filtered clock falls on the cycle the filter counter completes a low run.
  assign fall_edge = filt_clk && !clk_sync && (filt_cnt == FILT_W'(FILTER - 1));

  // Synchronise both pins and debounce the clock line.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
      filt_clk  <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_meta  <= PS2_CLK;
      clk_sync  <= clk_meta;
      data_meta <= PS2_DATA;
      data_sync <= data_meta;
      if (clk_sync == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_W'(FILTER - 1)) begin
        filt_clk <= clk_sync;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Watchdog expires TIMEOUT cycles after the last strobe of an open frame.
  assign timeout_hit = (bit_cnt != 4'd0) && !fall_edge && (wd == WD_W'(TIMEOUT - 1));

  // Shift in start/data/parity/stop bits and judge the frame on the stop bit.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      bit_cnt    <= 4'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      wd         <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (bit_cnt == 4'd0 || fall_edge || timeout_hit) wd <= '0;
      else                                            wd <= wd + 1'b1;

      if (timeout_hit) begin
        bit_cnt <= 4'd0;
      end else if (fall_edge) begin
        case (bit_cnt)
          4'd0: if (!data_sync) bit_cnt <= 4'd1;   // a high start bit is line noise
          4'd9: begin
            par_q   <= data_sync;
            bit_cnt <= 4'd10;
          end
          4'd10: begin
            bit_cnt    <= 4'd0;
            frame_done <= 1'b1;
            frame_ok   <= ((^shift_q) ^ par_q) & data_sync;
          end
          default: begin
            shift_q <= {data_sync, shift_q[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        endcase
      end
    end
  end

  // A good non-prefix byte becomes an event carrying the pending flags.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    push    = 1'b0;
    push_ev = '{code: shift_q, brk: brk_q, ext: ext_q};
    if (frame_done && frame_ok && shift_q != 8'hE0 && shift_q != 8'hF0) push = 1'b1;
  end

  // Track E0/F0 prefixes and flag discarded frames.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      FRAME_ERR <= timeout_hit || (frame_done && !frame_ok);
      if (timeout_hit || (frame_done && !frame_ok)) begin
        brk_q <= 1'b0;
        ext_q <= 1'b0;
      end else if (frame_done) begin
        if (shift_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (shift_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          brk_q <= 1'b0;
          ext_q <= 1'b0;
        end
      end
    end
  end

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign pop   = (count != '0) && OUT_READY;
  assign wr_en = push && (!full || pop);

  // Event storage.
  // NOTE: the array is not reset; the outputs are masked by OUT_VALID instead.
  always_ff @(posedge CLK) begin
    if (nRESET && wr_en) mem[wr_ptr] <= push_ev;
  end

  // FIFO pointers, occupancy and overflow pulse.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      OVERFLOW <= push && full && !pop;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // Present the head entry; all fields read zero while the FIFO is empty.
  always_comb begin
    OUT_VALID = (count != '0);
    OUT_CODE  = 8'h00;
    OUT_BREAK = 1'b0;
    OUT_EXT   = 1'b0;
    if (count != '0) begin
      OUT_CODE  = head.code;
      OUT_BREAK = head.brk;
      OUT_EXT   = head.ext;
    end
  end

endmodule
